// File: rtl/sort_req_scheduler_if.sv
// Bundle between the requester front-ends, the scheduler and the single shared byte sorter.
// master = scheduler side, slave = requesters plus sorter.
interface sort_req_scheduler_if #(
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*64-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               srt_valid;
  logic [63:0]        srt_data;
  logic               res_valid;
  logic [63:0]        res_data;
  logic [NREQ-1:0]    rsp_valid;
  logic [NREQ-1:0]    rsp_ready;
  logic [63:0]        rsp_data;
  logic               rsp_err;

  modport master (
    input  req_valid, req_data, res_valid, res_data, rsp_ready,
    output req_ready, srt_valid, srt_data, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    output req_valid, req_data, res_valid, res_data, rsp_ready,
    input  req_ready, srt_valid, srt_data, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/sort_req_scheduler.sv
// Round-robin scheduler sharing one 8-byte sorter between NREQ requesters.
// One frame in flight: accept, issue, wait (with timeout), respond to the owner.
module sort_req_scheduler #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  sort_req_scheduler_if.master bus
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e          state_q;
  logic [PW-1:0]   rr_ptr_q;
  logic [PW-1:0]   owner_q;
  logic [TW-1:0]   timer_q;
  logic            srt_valid_q;
  logic [63:0]     srt_data_q;
  logic [NREQ-1:0] rsp_valid_q;
  logic [63:0]     rsp_data_q;
  logic            rsp_err_q;

  logic            found;
  logic [PW-1:0]   winner;
  logic [PW-1:0]   cand;
  logic [PW-1:0]   ptr_nxt;
  logic [63:0]     win_frame;
  logic [NREQ-1:0] ready;
  logic [NREQ-1:0] owner_oh;
  int unsigned     idx;

  // First pending requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    cand   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx  = (32'(rr_ptr_q) + i) % NREQ;
      cand = idx[PW-1:0];
      if (!found && bus.req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    win_frame = '0;
    owner_oh  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (winner == PW'(i)) win_frame = bus.req_data[64*i +: 64];
      if (owner_q == PW'(i)) owner_oh[i] = 1'b1;
    end
    ptr_nxt = (winner == PW'(NREQ - 1)) ? '0 : winner + 1'b1;
  end

  // Accept strobe is combinational; gated by reset so every output reads 0 while held.
  always_comb begin
    ready = '0;
    if (rst_n && state_q == StIdle && found) ready[winner] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      timer_q     <= '0;
      srt_valid_q <= 1'b0;
      srt_data_q  <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (found) begin
            srt_data_q  <= win_frame;
            owner_q     <= winner;
            rr_ptr_q    <= ptr_nxt;
            srt_valid_q <= 1'b1;
            state_q     <= StIssue;
          end
        end
        StIssue: begin
          srt_valid_q <= 1'b0;
          timer_q     <= '0;
          state_q     <= StWait;
        end
        StWait: begin
          // A result arriving on the last timer cycle still wins over the timeout.
          if (bus.res_valid) begin
            rsp_data_q  <= bus.res_data;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= owner_oh;
            state_q     <= StResp;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= owner_oh;
            state_q     <= StResp;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        StResp: begin
          if (bus.rsp_ready[owner_q]) begin
            rsp_valid_q <= '0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready = ready;
  assign bus.srt_valid = srt_valid_q;
  assign bus.srt_data  = srt_data_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_sort_req_scheduler.sv
// Directed bench for sort_req_scheduler: latency, round-robin order, timeout,
// backpressure and asynchronous reset, with hand-computed expectations.
module tb_sort_req_scheduler;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sort_req_scheduler_if #(.NREQ(NREQ)) bus ();

  sort_req_scheduler #(
    .NREQ   (NREQ),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] frame(input int i);
    return 64'h0807060504030201 + 64'h1010101010101010 * 64'(i);
  endfunction

  function automatic logic [63:0] rev64(input logic [63:0] d);
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = d[8*(7-k) +: 8];
    return r;
  endfunction

  function automatic logic [63:0] oh(input int g);
    logic [63:0] r;
    r = 64'd1 << g;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".req_ready"}, 64'(bus.req_ready), 64'd0);
    check({tag, ".srt_valid"}, 64'(bus.srt_valid), 64'd0);
    check({tag, ".srt_data"},  bus.srt_data,       64'd0);
    check({tag, ".rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    check({tag, ".rsp_data"},  bus.rsp_data,       64'd0);
    check({tag, ".rsp_err"},   64'(bus.rsp_err),   64'd0);
  endtask

  // Full transaction with a sorter answering in the first WAIT cycle; rsp_ready assumed high.
  task automatic txn(input string tag, input logic [NREQ-1:0] valid, input int g);
    bus.req_valid = valid;
    #1;
    check({tag, ".grant"}, 64'(bus.req_ready), oh(g));
    step();
    check({tag, ".srt_valid"}, 64'(bus.srt_valid), 64'd1);
    check({tag, ".srt_data"},  bus.srt_data,       frame(g));
    check({tag, ".ready_busy"}, 64'(bus.req_ready), 64'd0);
    step();
    check({tag, ".srt_pulse"}, 64'(bus.srt_valid), 64'd0);
    bus.res_valid = 1'b1;
    bus.res_data  = rev64(frame(g));
    step();
    bus.res_valid = 1'b0;
    bus.res_data  = '0;
    check({tag, ".rsp_valid"}, 64'(bus.rsp_valid), oh(g));
    check({tag, ".rsp_data"},  bus.rsp_data,       rev64(frame(g)));
    check({tag, ".rsp_err"},   64'(bus.rsp_err),   64'd0);
    step();
    check({tag, ".rsp_done"}, 64'(bus.rsp_valid), 64'd0);
  endtask

  initial begin
    rst_n         = 1'b1;
    bus.req_valid = '0;
    bus.res_valid = 1'b0;
    bus.res_data  = '0;
    bus.rsp_ready = '1;
    for (int i = 0; i < int'(NREQ); i++) bus.req_data[64*i +: 64] = frame(i);
    #2;
    do_reset();
    check_all_zero("reset");

    // 1: single request, frame 0x0807..01 sorted to 0x0102..08
    txn("t1", 4'b0001, 0);
    check("t1.rsp_hold", bus.rsp_data, 64'h0102030405060708);
    bus.req_valid = '0;
    step();

    // 2: all requesting, order 0,1,2,3,0 at 4-cycle spacing
    do_reset();
    txn("t2.g0", 4'b1111, 0);
    txn("t2.g1", 4'b1111, 1);
    txn("t2.g2", 4'b1111, 2);
    txn("t2.g3", 4'b1111, 3);
    txn("t2.g0b", 4'b1111, 0);
    bus.req_valid = '0;

    // 3: steer rr_ptr to 2, then 1001 grants 3 then 0
    do_reset();
    txn("t3.p", 4'b0010, 1);
    txn("t3.g3", 4'b1001, 3);
    txn("t3.g0", 4'b1001, 0);
    bus.req_valid = '0;

    // 4: silent sorter -> timeout response; late result ignored
    bus.rsp_ready = '0;
    bus.req_valid = 4'b0001;
    #1;
    check("t4.grant", 64'(bus.req_ready), oh(0));
    step();
    bus.req_valid = '0;
    check("t4.srt_valid", 64'(bus.srt_valid), 64'd1);
    for (int c = 2; c <= 17; c++) step();
    check("t4.no_rsp_yet", 64'(bus.rsp_valid), 64'd0);
    step();
    check("t4.rsp_valid", 64'(bus.rsp_valid), oh(0));
    check("t4.rsp_err",   64'(bus.rsp_err),   64'd1);
    check("t4.rsp_data",  bus.rsp_data,       64'd0);
    step();
    check("t4.rsp_held", 64'(bus.rsp_valid), oh(0));
    bus.rsp_ready = '1;
    step();
    check("t4.rsp_done", 64'(bus.rsp_valid), 64'd0);
    bus.res_valid = 1'b1;
    bus.res_data  = 64'hdead_beef_cafe_f00d;
    step();
    bus.res_valid = 1'b0;
    bus.res_data  = '0;
    step();
    check("t4.late_data",  bus.rsp_data,       64'd0);
    check("t4.late_err",   64'(bus.rsp_err),   64'd1);
    check("t4.late_valid", 64'(bus.rsp_valid), 64'd0);
    txn("t4.after", 4'b0010, 1);

    // 5: backpressure on the response, rr_ptr is 2
    bus.rsp_ready = '0;
    bus.req_valid = 4'b1111;
    #1;
    check("t5.grant", 64'(bus.req_ready), oh(2));
    step();
    step();
    bus.res_valid = 1'b1;
    bus.res_data  = rev64(frame(2));
    step();
    bus.res_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("t5.hold_valid", 64'(bus.rsp_valid), oh(2));
      check("t5.hold_data",  bus.rsp_data,       rev64(frame(2)));
      check("t5.no_grant",   64'(bus.req_ready), 64'd0);
      step();
    end
    bus.rsp_ready = '1;
    step();
    check("t5.idle_rsp", 64'(bus.rsp_valid), 64'd0);
    check("t5.idle_grant", 64'(bus.req_ready), oh(3));
    bus.req_valid = '0;
    step();
    check("t5.no_accept", 64'(bus.srt_valid), 64'd0);

    // 6: asynchronous reset during WAIT, then arbitration restarts at 0
    do_reset();
    txn("t6.a", 4'b0100, 2);
    bus.req_valid = 4'b0011;
    #1;
    check("t6.wrap_grant", 64'(bus.req_ready), oh(0));
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("t6.async");
    step();
    rst_n = 1'b1;
    bus.req_valid = 4'b1111;
    #1;
    check("t6.post_grant", 64'(bus.req_ready), oh(0));
    step();
    check("t6.post_srt", 64'(bus.srt_valid), 64'd1);
    check("t6.post_data", bus.srt_data, frame(0));
    bus.req_valid = '0;
    step();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
